// File: rtl/core_pkg.sv
// Shared lane VRF types and widths used by the write-back arbiter.
package core_pkg;

  // Default lane configuration: VALU, VMUL, VLSU writing into 4 banks.
  localparam int DefNrVFU  = 3;
  localparam int DefNrBank = 4;
  localparam int LogNrBank = $clog2(DefNrBank);

  localparam int VrfAddrW     = 10;
  localparam int VrfDataW     = 64;
  localparam int VrfStrbW     = VrfDataW / 8;
  localparam int InsnIdW      = 3;
  localparam int VrfBankAddrW = VrfAddrW - LogNrBank;

  typedef logic [VrfAddrW-1:0]     vrf_addr_t;
  typedef logic [VrfDataW-1:0]     vrf_data_t;
  typedef logic [VrfStrbW-1:0]     vrf_strb_t;
  typedef logic [InsnIdW-1:0]      insn_id_t;
  typedef logic [VrfBankAddrW-1:0] vrf_bank_addr_t;

endpackage

// File: rtl/rr_bank_arbiter.sv
// Single-bank round-robin arbiter. Grants the first requester found
// scanning upward from the priority pointer; a busy bank grants nobody
// and keeps its pointer.
module rr_bank_arbiter #(
  parameter  int NrReq = 3,
  localparam int PtrW  = (NrReq > 1) ? $clog2(NrReq) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [NrReq-1:0] req_i,
  input  logic             busy_i,
  output logic [NrReq-1:0] gnt_o
);

  logic [PtrW-1:0] rr_q, rr_d;
  logic            found;
  int              idx;

  // Scan from the pointer, grant the first requester, move the pointer past it.
  always_comb begin
    gnt_o = '0;
    rr_d  = rr_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NrReq; k++) begin
      idx = (int'(rr_q) + k) % NrReq;
      if (rst_ni && !busy_i && !found && req_i[PtrW'(idx)]) begin
        found              = 1'b1;
        gnt_o[PtrW'(idx)]  = 1'b1;
        rr_d               = PtrW'((idx + 1) % NrReq);
      end
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end

endmodule

// File: rtl/vrf_write_arbiter.sv
// Per-lane VRF write-back arbiter. Decodes each requester's target bank,
// runs one round-robin arbiter per bank, returns a same-cycle grant and
// registers the winning write into the bank SRAM ports plus a commit pulse.
module vrf_write_arbiter
  import core_pkg::*;
#(
  parameter  int NrVFU     = DefNrVFU,
  parameter  int NrBank    = DefNrBank,
  localparam int LogBank   = $clog2(NrBank),
  localparam int BankAddrW = VrfAddrW - LogBank
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NrVFU-1:0]                   wb_valid_i,
  output logic [NrVFU-1:0]                   wb_gnt_o,
  input  logic [NrVFU-1:0][VrfAddrW-1:0]     wb_addr_i,
  input  logic [NrVFU-1:0][VrfDataW-1:0]     wb_data_i,
  input  logic [NrVFU-1:0][VrfStrbW-1:0]     wb_strb_i,
  input  logic [NrVFU-1:0][InsnIdW-1:0]      wb_id_i,
  input  logic [NrBank-1:0]                  bank_rd_busy_i,
  output logic [NrBank-1:0]                  bank_we_o,
  output logic [NrBank-1:0][BankAddrW-1:0]   bank_addr_o,
  output logic [NrBank-1:0][VrfDataW-1:0]    bank_wdata_o,
  output logic [NrBank-1:0][VrfStrbW-1:0]    bank_wstrb_o,
  output logic [NrVFU-1:0]                   wb_commit_valid_o,
  output logic [NrVFU-1:0][InsnIdW-1:0]      wb_commit_id_o
);

  logic [NrVFU-1:0] bank_req [NrBank];
  logic [NrVFU-1:0] bank_gnt [NrBank];

  logic [NrBank-1:0]                 bank_we_d, bank_we_q;
  logic [NrBank-1:0][BankAddrW-1:0]  bank_addr_d, bank_addr_q;
  logic [NrBank-1:0][VrfDataW-1:0]   bank_wdata_d, bank_wdata_q;
  logic [NrBank-1:0][VrfStrbW-1:0]   bank_wstrb_d, bank_wstrb_q;
  logic [NrVFU-1:0]                  commit_valid_q;
  logic [NrVFU-1:0][InsnIdW-1:0]     commit_id_q;

  // Bank decode: the low address bits select the bank each requester targets.
  always_comb begin
    for (int b = 0; b < NrBank; b++) begin
      bank_req[b] = '0;
      for (int i = 0; i < NrVFU; i++) begin
        bank_req[b][i] = wb_valid_i[i] && (wb_addr_i[i][LogBank-1:0] == LogBank'(b));
      end
    end
  end

  for (genvar b = 0; b < NrBank; b++) begin : g_bank
    rr_bank_arbiter #(
      .NrReq (NrVFU)
    ) u_arb (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .req_i  (bank_req[b]),
      .busy_i (bank_rd_busy_i[b]),
      .gnt_o  (bank_gnt[b])
    );
  end

  // OR bank grants back to requesters and select each bank's winning write.
  // Grants depend only on valid/address/busy, never on write data.
  always_comb begin
    wb_gnt_o     = '0;
    bank_we_d    = '0;
    bank_addr_d  = '0;
    bank_wdata_d = '0;
    bank_wstrb_d = '0;
    for (int b = 0; b < NrBank; b++) begin
      for (int i = 0; i < NrVFU; i++) begin
        if (bank_gnt[b][i]) begin
          wb_gnt_o[i]     = 1'b1;
          bank_we_d[b]    = 1'b1;
          bank_addr_d[b]  = wb_addr_i[i][VrfAddrW-1:LogBank];
          bank_wdata_d[b] = wb_data_i[i];
          bank_wstrb_d[b] = wb_strb_i[i];
        end
      end
    end
  end

  // Write and commit registers; payload holds unless its bank or requester was granted.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      bank_we_q      <= '0;
      bank_addr_q    <= '0;
      bank_wdata_q   <= '0;
      bank_wstrb_q   <= '0;
      commit_valid_q <= '0;
      commit_id_q    <= '0;
    end else begin
      bank_we_q      <= bank_we_d;
      commit_valid_q <= wb_gnt_o;
      for (int b = 0; b < NrBank; b++) begin
        if (bank_we_d[b]) begin
          bank_addr_q[b]  <= bank_addr_d[b];
          bank_wdata_q[b] <= bank_wdata_d[b];
          bank_wstrb_q[b] <= bank_wstrb_d[b];
        end
      end
      for (int i = 0; i < NrVFU; i++) begin
        if (wb_gnt_o[i]) begin
          commit_id_q[i] <= wb_id_i[i];
        end
      end
    end
  end

  assign bank_we_o         = bank_we_q;
  assign bank_addr_o       = bank_addr_q;
  assign bank_wdata_o      = bank_wdata_q;
  assign bank_wstrb_o      = bank_wstrb_q;
  assign wb_commit_valid_o = commit_valid_q;
  assign wb_commit_id_o    = commit_id_q;

endmodule

// File: tb/tb_vrf_write_arbiter.sv
// Bench for vrf_write_arbiter: directed scenarios followed by randomized
// traffic, all compared cycle by cycle against a behavioural model.
module tb_vrf_write_arbiter;

  localparam int NV = 3;
  localparam int NB = 4;
  localparam int NTXN = 300;

  logic clk = 1'b0;
  logic rst_n;
  logic [NV-1:0]        valid, gnt;
  logic [NV-1:0][9:0]   addr;
  logic [NV-1:0][63:0]  data;
  logic [NV-1:0][7:0]   strb;
  logic [NV-1:0][2:0]   id;
  logic [NB-1:0]        busy, we;
  logic [NB-1:0][7:0]   baddr;
  logic [NB-1:0][63:0]  bdata;
  logic [NB-1:0][7:0]   bstrb;
  logic [NV-1:0]        cv;
  logic [NV-1:0][2:0]   cid;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Behavioural model state.
  int                   rr  [NB];
  int                   win [NB];
  logic [NV-1:0]        m_gnt, obs_gnt;
  logic [NB-1:0]        m_we;
  logic [NB-1:0][7:0]   m_baddr;
  logic [NB-1:0][63:0]  m_bdata;
  logic [NB-1:0][7:0]   m_bstrb;
  logic [NV-1:0]        m_cv;
  logic [NV-1:0][2:0]   m_cid;

  typedef struct packed {
    logic [9:0]  a;
    logic [63:0] d;
    logic [7:0]  s;
    logic [2:0]  t;
  } txn_t;
  txn_t fifo [NV][$];

  always #5 clk = ~clk;

  vrf_write_arbiter dut (
    .clk_i             (clk),
    .rst_ni            (rst_n),
    .wb_valid_i        (valid),
    .wb_gnt_o          (gnt),
    .wb_addr_i         (addr),
    .wb_data_i         (data),
    .wb_strb_i         (strb),
    .wb_id_i           (id),
    .bank_rd_busy_i    (busy),
    .bank_we_o         (we),
    .bank_addr_o       (baddr),
    .bank_wdata_o      (bdata),
    .bank_wstrb_o      (bstrb),
    .wb_commit_valid_o (cv),
    .wb_commit_id_o    (cid)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic set_idle();
    valid = '0;
    busy  = '0;
    addr  = '0;
    data  = '0;
    strb  = '0;
    id    = '0;
  endtask

  task automatic set_req(input int i, input logic [9:0] a, input logic [63:0] d,
                         input logic [7:0] s, input logic [2:0] t);
    valid[i] = 1'b1;
    addr[i]  = a;
    data[i]  = d;
    strb[i]  = s;
    id[i]    = t;
  endtask

  // One clock cycle: predict grants from the held inputs, compare, clock,
  // update the model's registered view and compare the registered outputs.
  task automatic do_cycle();
    #1;
    m_gnt = '0;
    for (int b = 0; b < NB; b++) win[b] = -1;
    if (rst_n) begin
      for (int b = 0; b < NB; b++) begin
        if (!busy[b]) begin
          for (int k = 0; k < NV; k++) begin
            int r;
            r = (rr[b] + k) % NV;
            if (win[b] < 0 && valid[r] && (int'(addr[r]) % NB) == b) begin
              win[b]   = r;
              m_gnt[r] = 1'b1;
            end
          end
        end
      end
    end
    obs_gnt = gnt;
    chk("wb_gnt", gnt, m_gnt);
    chk("gnt_without_valid", gnt & ~valid, '0);
    @(posedge clk);
    if (!rst_n) begin
      for (int b = 0; b < NB; b++) rr[b] = 0;
      m_we = '0; m_baddr = '0; m_bdata = '0; m_bstrb = '0;
      m_cv = '0; m_cid = '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (win[b] >= 0) begin
          m_we[b]    = 1'b1;
          m_baddr[b] = 8'(int'(addr[win[b]]) / NB);
          m_bdata[b] = data[win[b]];
          m_bstrb[b] = strb[win[b]];
          rr[b]      = (win[b] + 1) % NV;
        end else begin
          m_we[b] = 1'b0;
        end
      end
      m_cv = m_gnt;
      for (int i = 0; i < NV; i++) if (m_gnt[i]) m_cid[i] = id[i];
    end
    #1;
    chk("bank_we", we, m_we);
    for (int b = 0; b < NB; b++) begin
      chk($sformatf("bank_addr[%0d]", b), baddr[b], m_baddr[b]);
      chk($sformatf("bank_wdata[%0d]", b), bdata[b], m_bdata[b]);
      chk($sformatf("bank_wstrb[%0d]", b), bstrb[b], m_bstrb[b]);
    end
    chk("commit_valid", cv, m_cv);
    for (int i = 0; i < NV; i++) chk($sformatf("commit_id[%0d]", i), cid[i], m_cid[i]);
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog cyc=%0d observed=running required=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int gen;
    int done;
    logic [2:0] expv;
    gen  = 0;
    done = 0;
    for (int b = 0; b < NB; b++) rr[b] = 0;
    m_we = '0; m_baddr = '0; m_bdata = '0; m_bstrb = '0; m_cv = '0; m_cid = '0;
    rst_n = 1'b0;
    set_idle();

    // Reset with a pending request: no grant, everything cleared.
    set_req(0, 10'h0D, 64'h1, 8'h01, 3'd1);
    do_cycle();
    do_cycle();
    chk("reset_gnt", obs_gnt, 3'b000);
    chk("reset_we", we, 4'b0000);
    chk("reset_commit", cv, 3'b000);
    rst_n = 1'b1;
    set_idle();
    do_cycle();

    // Single VALU request to bank 1, local address 3.
    set_req(0, 10'h0D, 64'hDEADBEEF_01234567, 8'hFF, 3'd5);
    do_cycle();
    chk("single_gnt", obs_gnt, 3'b001);
    chk("single_we", we, 4'b0010);
    chk("single_addr", baddr[1], 8'h03);
    chk("single_data", bdata[1], 64'hDEADBEEF_01234567);
    chk("single_strb", bstrb[1], 8'hFF);
    chk("single_commit", cv, 3'b001);
    chk("single_commit_id", cid[0], 3'd5);
    set_idle();
    do_cycle();
    chk("single_we_drop", we, 4'b0000);

    // VALU and VMUL contend for bank 2; VMUL uses an all-zero strobe.
    set_req(0, 10'h002, 64'hA5A5_0000_1111_2222, 8'h0F, 3'd1);
    set_req(1, 10'h006, 64'h5A5A_3333_4444_5555, 8'h00, 3'd2);
    for (int k = 0; k < 3; k++) begin
      expv = (k % 2 == 0) ? 3'b001 : 3'b010;
      do_cycle();
      chk("conflict_gnt", obs_gnt, expv);
      chk("conflict_we", we, 4'b0100);
    end
    set_idle();
    do_cycle();

    // Three requesters on three different banks.
    set_req(0, 10'h000, 64'h10, 8'h11, 3'd3);
    set_req(1, 10'h001, 64'h20, 8'h22, 3'd4);
    set_req(2, 10'h002, 64'h30, 8'h33, 3'd6);
    do_cycle();
    chk("parallel_gnt", obs_gnt, 3'b111);
    chk("parallel_we", we, 4'b0111);
    set_idle();
    do_cycle();

    // Bank 3 busy with reads for 3 cycles while VLSU waits.
    set_req(2, 10'h03F, 64'hCAFE_F00D_0000_0003, 8'hF0, 3'd7);
    busy = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      do_cycle();
      chk("rdbusy_gnt", obs_gnt, 3'b000);
      chk("rdbusy_we", we, 4'b0000);
    end
    busy = 4'b0000;
    do_cycle();
    chk("rdbusy_release_gnt", obs_gnt, 3'b100);
    chk("rdbusy_release_we", we, 4'b1000);
    chk("rdbusy_release_addr", baddr[3], 8'h0F);
    set_idle();
    do_cycle();

    // Grant to VALU on bank 2, then reset the following cycle.
    set_req(0, 10'h00A, 64'h77, 8'h03, 3'd2);
    do_cycle();
    chk("midrst_first_gnt", obs_gnt, 3'b001);
    rst_n = 1'b0;
    do_cycle();
    chk("midrst_gnt", obs_gnt, 3'b000);
    chk("midrst_we", we, 4'b0000);
    chk("midrst_commit", cv, 3'b000);
    rst_n = 1'b1;
    set_req(0, 10'h00A, 64'h88, 8'h0C, 3'd3);
    set_req(1, 10'h00E, 64'h99, 8'h30, 3'd4);
    do_cycle();
    chk("midrst_ptr_cleared", obs_gnt, 3'b001);
    set_idle();
    do_cycle();

    // Randomized traffic: each requester drains its own FIFO, banks randomly busy.
    for (int c = 0; c < 4000; c++) begin
      if (gen == NTXN && fifo[0].size() == 0 && fifo[1].size() == 0 && fifo[2].size() == 0) break;
      for (int i = 0; i < NV; i++) begin
        if (gen < NTXN && fifo[i].size() < 4 && $urandom_range(0, 2) != 0) begin
          txn_t t;
          t.a = {8'($urandom), 2'($urandom_range(0, 3))};
          t.d = {$urandom, $urandom};
          t.s = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
          t.t = 3'($urandom);
          fifo[i].push_back(t);
          gen++;
        end
      end
      for (int i = 0; i < NV; i++) begin
        if (fifo[i].size() > 0) begin
          set_req(i, fifo[i][0].a, fifo[i][0].d, fifo[i][0].s, fifo[i][0].t);
        end else begin
          valid[i] = 1'b0;
          addr[i]  = 10'($urandom);
          data[i]  = {$urandom, $urandom};
          strb[i]  = 8'($urandom);
          id[i]    = 3'($urandom);
        end
      end
      for (int b = 0; b < NB; b++) busy[b] = ($urandom_range(0, 3) == 0);
      do_cycle();
      for (int i = 0; i < NV; i++) begin
        if (m_gnt[i] && fifo[i].size() > 0) begin
          void'(fifo[i].pop_front());
          done++;
        end
      end
    end
    chk("random_all_written", done, NTXN);
    set_idle();
    do_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
